slave_ram: RTL and testbench

Synthesizable word-addressed memory slave that sits directly downstream of the 2-master/2-slave crossbar on either slave port. It accepts one request at a time on the crossbar's req/ack slave handshake and performs a read or write against an internal array. It answers with a one-cycle ack after a fixed, parameterized latency, so crossbar arbitration and hold behaviour can be exercised against a realistic, non-zero-wait target.

---
 rtl/slave_ram_if.sv | 11 +
 rtl/slave_ram.sv | 65 ++++++
 tb/tb_slave_ram.sv | 118 +++++++++++
 3 files changed

// File: rtl/slave_ram_if.sv
// slave_ram_if: req/ack handshake between a crossbar slave port and a memory target.
interface slave_ram_if;
   logic        req;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        cmd;
   logic        ack;
   logic [31:0] rdata;
   modport master (output req, addr, wdata, cmd, input ack, rdata);
   modport slave (input req, addr, wdata, cmd, output ack, rdata);
endinterface

// File: rtl/slave_ram.sv
// slave_ram: word-addressed 32-bit memory target answering each request with a one-cycle ack
// after a fixed LATENCY, one transaction at a time.
module slave_ram #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input logic        clk,
   input logic        rst_n,
   slave_ram_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   logic [1:0]        state, next;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] idx, idx_eff;
   logic              wr, wr_eff;
   logic [31:0]       wd, rdata;
   logic [31:0]       mem [2**ADDR_W];
   logic              unused;

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("slave_ram: LATENCY must be in 1..15");
   end

   // byte-lane bits and crossbar routing bits carry no meaning here
   assign unused = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

   // with LATENCY=1 the array is read on the accepting edge, before the latches are loaded
   always_comb begin
      next    = state == IDLE ? (bus.req ? (LATENCY == 1 ? ACK : WAIT) : IDLE)
              : state == WAIT ? (cnt == 4'd1 ? ACK : WAIT) : IDLE;
      idx_eff = state == IDLE ? bus.addr[ADDR_W+1:2] : idx;
      wr_eff  = state == IDLE ? bus.cmd : wr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         rdata <= '0;
         idx   <= '0;
         wr    <= 1'b0;
         wd    <= '0;
      end else begin
         state <= next;
         if (state == IDLE && bus.req) begin
            cnt <= CNT_LOAD;
            idx <= bus.addr[ADDR_W+1:2];
            wr  <= bus.cmd;
            wd  <= bus.wdata;
         end else if (state == WAIT) cnt <= cnt - 4'd1;
         if (next == ACK && !wr_eff) rdata <= mem[idx_eff];
      end
   end

   // commit on the edge leaving ACK so a following read sees the new word
   always_ff @(posedge clk)
      if (state == ACK && wr) mem[idx] <= wd;

   assign bus.ack   = state == ACK;
   assign bus.rdata = rdata;
endmodule

// File: tb/tb_slave_ram.sv
// tb_slave_ram: directed checks of three slave_ram builds (LATENCY 2, 1, 15).
module tb_slave_ram;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   slave_ram_if b0 ();
   slave_ram_if b1 ();
   slave_ram_if b2 ();

   slave_ram #(.ADDR_W(8), .LATENCY(2))  u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   slave_ram #(.ADDR_W(8), .LATENCY(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   slave_ram #(.ADDR_W(8), .LATENCY(15)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic r, input logic c, input logic [31:0] a, input logic [31:0] w);
      case (d)
         0: begin b0.req = r; b0.cmd = c; b0.addr = a; b0.wdata = w; end
         1: begin b1.req = r; b1.cmd = c; b1.addr = a; b1.wdata = w; end
         default: begin b2.req = r; b2.cmd = c; b2.addr = a; b2.wdata = w; end
      endcase
   endtask

   function automatic logic [31:0] ack_of(input int d);
      return 32'(d == 0 ? b0.ack : d == 1 ? b1.ack : b2.ack);
   endfunction

   function automatic logic [31:0] rd_of(input int d);
      return d == 0 ? b0.rdata : d == 1 ? b1.rdata : b2.rdata;
   endfunction

   // starts at a falling edge in an IDLE cycle; ends at the falling edge of the next IDLE cycle
   task automatic run(input string tag, input int d, input int lat, input logic c,
                      input logic [31:0] a, input logic [31:0] w, input logic [31:0] exp_rd, input bit tog);
      drive(d, 1'b1, c, a, w);
      chk({tag, ".ack_c0"}, ack_of(d), 32'd0);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k < lat) begin
            chk({tag, ".ack_wait"}, ack_of(d), 32'd0);
            if (tog) drive(d, 1'b1, ~c, $urandom, $urandom);
         end else begin
            chk({tag, ".ack"}, ack_of(d), 32'd1);
            chk({tag, ".rdata"}, rd_of(d), exp_rd);
            drive(d, 1'b0, c, a, w);
         end
      end
      @(negedge clk);
      chk({tag, ".ack_off"}, ack_of(d), 32'd0);
   endtask

   initial begin
      drive(0, 1'b1, 1'b1, 32'h14, 32'h55);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      chk("rst.ack", ack_of(0), 32'd0);
      chk("rst.rdata0", rd_of(0), 32'd0);
      chk("rst.rdata1", rd_of(1), 32'd0);
      chk("rst.rdata2", rd_of(2), 32'd0);
      rst_n = 1'b1;
      run("rel", 0, 2, 1'b1, 32'h14, 32'h55, 32'd0, 1'b0);

      run("wr10", 0, 2, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'd0, 1'b0);
      run("rd80", 0, 2, 1'b0, 32'h8000_0010, 32'h0, 32'hDEADBEEF, 1'b0);

      for (int i = 0; i < 4; i++)
         run("pre", 0, 2, 1'b1, 32'(i * 4), 32'(32'h11 * (i + 1)), 32'hDEADBEEF, 1'b0);

      for (int cy = 0; cy < 12; cy++) begin
         chk("b2b.ack", ack_of(0), 32'(cy % 3 == 2));
         if (cy % 3 == 2) chk("b2b.rdata", rd_of(0), 32'(32'h11 * (cy / 3 + 1)));
         drive(0, cy < 11, 1'b0, 32'(((cy + 1) / 3) * 4), 32'h0);
         @(negedge clk);
      end
      chk("b2b.ack_off", ack_of(0), 32'd0);

      run("l1w", 1, 1, 1'b1, 32'h0C, 32'h13579BDF, 32'd0, 1'b1);
      run("l1r", 1, 1, 1'b0, 32'h0C, 32'h0, 32'h13579BDF, 1'b1);
      run("l15w", 2, 15, 1'b1, 32'h20, 32'h2468ACE0, 32'd0, 1'b1);
      run("l15r", 2, 15, 1'b0, 32'h20, 32'h0, 32'h2468ACE0, 1'b1);

      run("a5w", 0, 2, 1'b1, 32'h24, 32'hA5A5A5A5, 32'h44, 1'b0);
      run("a5r", 0, 2, 1'b0, 32'h24, 32'h0, 32'hA5A5A5A5, 1'b0);
      run("a5w2", 0, 2, 1'b1, 32'h24, 32'h0, 32'hA5A5A5A5, 1'b0);
      run("a5r2", 0, 2, 1'b0, 32'h24, 32'h0, 32'h0, 1'b0);

      run("mw", 0, 2, 1'b1, 32'h1C, 32'h12345678, 32'h0, 1'b0);
      run("mr", 0, 2, 1'b0, 32'h1C, 32'h0, 32'h12345678, 1'b0);
      drive(0, 1'b1, 1'b1, 32'h1C, 32'hCAFEF00D);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid.rdata", rd_of(0), 32'd0);
      drive(0, 1'b0, 1'b0, 32'h1C, 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("mid.ack", ack_of(0), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid.ack_rel", ack_of(0), 32'd0);
      run("mrd", 0, 2, 1'b0, 32'h1C, 32'h0, 32'h12345678, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
